mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Multicycle memory target that answers the control unit's mem_read/mem_write requests during instruction fetch (IF1–IF4) and data access (MEM1–MEM3).
- Latches one request, stays busy for a fixed LATENCY, then pulses mem_ready with read data or write completion.
- Sits between the datapath/control FSM and the word-addressed storage array.
- The control FSM advances out of its wait states only on mem_ready.

Parameters:
- WORD_W, 32, data word width in bits.
- ADDR_W, 32, byte-address width.
- DEPTH, 256, number of words in storage; power of two.
- LATENCY, 3, cycles from request acceptance to mem_ready; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- mem_read  input  1  read request, sampled only in IDLE.
- mem_write  input  1  write request, sampled only in IDLE.
- addr  input  ADDR_W  byte address; word index = addr[log2(DEPTH)+1:2].
- data_in  input  WORD_W  write data.
- data_out  output  WORD_W  read data; valid when mem_ready=1.
- mem_ready  output  1  one-cycle completion pulse.
- busy  output  1  high while a request is in flight.
- err  output  1  one-cycle pulse on an illegal request.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is synchronous and active-high on reset.
- Reset values:
  - State = IDLE.
  - mem_ready=0, busy=0, err=0, data_out=0.
  - Latched request and latency counter cleared.
  - Storage array is NOT cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Exactly one of mem_read or mem_write high → latch op, word index and data_in.
  - Then load counter = LATENCY-1, busy=1 on the next cycle, go to WAIT; if LATENCY=1, go directly to RESP.
  - Both mem_read and mem_write high → no accept, err=1 next cycle for 1 cycle, stay IDLE.
  - Neither high → stay IDLE.
- WAIT:
  - Counter decrements each cycle.
  - At counter==1, transition to RESP.
  - addr, data_in, mem_read and mem_write are ignored (latched copies used).
- RESP (one cycle):
  - mem_ready=1, busy=1.
  - Read: data_out = array[latched index].
  - Write: array[latched index] written on the RESP clock edge; data_out holds its previous value.
  - Always returns to IDLE next cycle.
- Timing:
  - Request sampled at edge T → mem_ready high during cycle T+LATENCY.
  - Back-to-back: a new request present in the cycle after RESP is accepted (throughput one request per LATENCY+1 cycles).
- data_out holds its last read value until the next read completes.
- Addressing:
  - addr[1:0] ignored (word aligned).
  - Address bits above the index are ignored: wrap modulo DEPTH words.
- Reset mid-operation (WAIT or RESP):
  - Abort to IDLE; pending write is NOT committed.
  - mem_ready is not pulsed; outputs take reset values.
- Reset asserted together with a request: reset wins; request dropped.
- Read-after-write to the same address in consecutive requests returns the new data.

Decomposition:
- Shared package (mem_pkg):
  - State encoding constants MS_IDLE=2'd0, MS_WAIT=2'd1, MS_RESP=2'd2.
  - Default WORD_W/ADDR_W/DEPTH/LATENCY constants.
  - Op encoding OP_READ=1'b0, OP_WRITE=1'b1.
- One natural sub-module, word_ram:
  - Single-port synchronous array, parameters WORD_W/DEPTH.
  - Ports clk, we, idx, wdata, rdata.
  - Read registered on the same edge as the RESP write decision.
- mem_responder holds the FSM, counter and request latches.

Test Plan:
- Reset, then idle 5 cycles → mem_ready=0, busy=0, err=0, data_out=0 throughout.
- Write addr=0x10, data_in=0xDEADBEEF at T; read addr=0x10 once IDLE → each mem_ready exactly at T+3 of its own request; read data_out=0xDEADBEEF; busy high for 3 cycles per request.
- Request held high across the whole transaction with addr changed to 0x20 during WAIT → operation uses latched 0x10; only one mem_ready per accept.
- mem_read=mem_write=1 in IDLE → err=1 for one cycle, busy stays 0, no mem_ready; a following clean read proceeds normally.
- Write 0x12345678 to addr=0x400 (DEPTH=256) → read addr=0x0 returns 0x12345678 (wrap); read addr=0x3 returns word 0.
- Write to 0x8 with data 0xAAAA0000, assert reset during WAIT → no mem_ready, FSM in IDLE; read of 0x8 returns the prior value (write not committed).

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types and defaults for the multicycle memory responder.
// State and op encodings are common to the FSM, the RAM wrapper and benches.
package mem_pkg;

  localparam int DEF_WORD_W  = 32;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DEPTH   = 256;
  localparam int DEF_LATENCY = 3;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_WAIT = 2'd1,
    MS_RESP = 2'd2
  } ms_state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  function automatic bit lat_ok(int lat);
    return (lat >= 1) && (lat <= 15);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the control unit and the memory responder.
// The control side is the master; the responder is the slave.
interface mem_responder_if
  import mem_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] data_in;
  logic [WORD_W-1:0] data_out;
  logic              mem_ready;
  logic              busy;
  logic              err;

  modport master (
    output mem_read,
    output mem_write,
    output addr,
    output data_in,
    input  data_out,
    input  mem_ready,
    input  busy,
    input  err
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  addr,
    input  data_in,
    output data_out,
    output mem_ready,
    output busy,
    output err
  );

endinterface

// File: rtl/mem_responder_ram.sv
// Single-port word array with a registered read port.
// Contents are deliberately not reset.
module word_ram #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 256,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wdata;
    end
    rdata <= mem_q[idx];
  end

endmodule

// File: rtl/mem_responder.sv
// Multicycle memory target: latches one request, waits LATENCY cycles,
// then pulses mem_ready with read data or write completion.
module mem_responder
  import mem_pkg::*;
#(
  parameter int WORD_W  = DEF_WORD_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);

  if (!lat_ok(LATENCY)) begin : g_bad_latency
    $error("mem_responder: LATENCY must be 1..15");
  end

  ms_state_e         state_q, state_d;
  op_e               op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] dout_q, dout_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic [IDX_W-1:0]  addr_idx;
  logic [IDX_W-1:0]  ram_idx;
  logic [WORD_W-1:0] ram_rdata;
  logic              ram_we;
  logic              rd_resp;
  logic              unused_addr;

  assign addr_idx    = bus.addr[IDX_W+1:2];
  assign unused_addr = ^{bus.addr[ADDR_W-1:IDX_W+2], bus.addr[1:0]};

  // Steer the live address in IDLE so LATENCY=1 reads are ready in RESP.
  assign ram_idx = (state_q == MS_IDLE) ? addr_idx : idx_q;
  assign ram_we  = (state_q == MS_RESP) && (op_q == OP_WRITE) && !reset;
  assign rd_resp = (state_q == MS_RESP) && (op_q == OP_READ);

  word_ram #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .idx   (ram_idx),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    ready_d = 1'b0;
    busy_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      MS_IDLE: begin
        if (bus.mem_read ^ bus.mem_write) begin
          op_d    = bus.mem_write ? OP_WRITE : OP_READ;
          idx_d   = addr_idx;
          wdata_d = bus.data_in;
          cnt_d   = CNT_W'(LATENCY - 1);
          busy_d  = 1'b1;
          if (LATENCY == 1) begin
            state_d = MS_RESP;
            ready_d = 1'b1;
          end else begin
            state_d = MS_WAIT;
          end
        end else if (bus.mem_read && bus.mem_write) begin
          err_d = 1'b1;
        end
      end
      MS_WAIT: begin
        cnt_d  = cnt_q - CNT_W'(1);
        busy_d = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = MS_RESP;
          ready_d = 1'b1;
        end
      end
      MS_RESP: begin
        state_d = MS_IDLE;
        if (op_q == OP_READ) begin
          dout_d = ram_rdata;
        end
      end
      default: begin
        state_d = MS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MS_IDLE;
      op_q    <= OP_READ;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Read data comes straight from the RAM register during RESP, then holds.
  assign bus.data_out  = rd_resp ? ram_rdata : dout_q;
  assign bus.mem_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder at default parameters (LATENCY=3).
// Expected values are hand-computed per step.
module tb_mem_responder;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_responder_if bus ();

  mem_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.addr      = '0;
    bus.data_in   = '0;
  endtask

  task automatic txn(input string tag, input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_dout);
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.addr      = a;
    bus.data_in   = d;
    tick();
    idle_in();
    chk({tag, ".busy1"}, 32'(bus.busy), 32'd1);
    chk({tag, ".rdy1"}, 32'(bus.mem_ready), 32'd0);
    tick();
    chk({tag, ".busy2"}, 32'(bus.busy), 32'd1);
    chk({tag, ".rdy2"}, 32'(bus.mem_ready), 32'd0);
    tick();
    chk({tag, ".busy3"}, 32'(bus.busy), 32'd1);
    chk({tag, ".rdy3"}, 32'(bus.mem_ready), 32'd1);
    chk({tag, ".dout"}, bus.data_out, exp_dout);
    tick();
    chk({tag, ".busy4"}, 32'(bus.busy), 32'd0);
    chk({tag, ".rdy4"}, 32'(bus.mem_ready), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    idle_in();
    tick();
    tick();
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst.rdy", 32'(bus.mem_ready), 32'd0);
      chk("rst.busy", 32'(bus.busy), 32'd0);
      chk("rst.err", 32'(bus.err), 32'd0);
      chk("rst.dout", bus.data_out, 32'd0);
    end

    txn("wr10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0);
    txn("rd10", 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
    chk("rd10.hold", bus.data_out, 32'hDEADBEEF);
    txn("wr20", 1'b0, 1'b1, 32'h20, 32'h22222222, 32'hDEADBEEF);

    // Held read: addr changes during WAIT, then re-accepted after RESP.
    bus.mem_read = 1'b1;
    bus.addr     = 32'h10;
    tick();
    bus.addr = 32'h20;
    chk("hold.busy1", 32'(bus.busy), 32'd1);
    chk("hold.rdy1", 32'(bus.mem_ready), 32'd0);
    tick();
    chk("hold.rdy2", 32'(bus.mem_ready), 32'd0);
    tick();
    chk("hold.rdy3", 32'(bus.mem_ready), 32'd1);
    chk("hold.dout", bus.data_out, 32'hDEADBEEF);
    tick();
    chk("hold.idle.rdy", 32'(bus.mem_ready), 32'd0);
    chk("hold.idle.busy", 32'(bus.busy), 32'd0);
    tick();
    bus.mem_read = 1'b0;
    chk("b2b.busy1", 32'(bus.busy), 32'd1);
    chk("b2b.rdy1", 32'(bus.mem_ready), 32'd0);
    tick();
    chk("b2b.rdy2", 32'(bus.mem_ready), 32'd0);
    tick();
    chk("b2b.rdy3", 32'(bus.mem_ready), 32'd1);
    chk("b2b.dout", bus.data_out, 32'h22222222);
    tick();
    chk("b2b.rdy4", 32'(bus.mem_ready), 32'd0);
    chk("b2b.busy4", 32'(bus.busy), 32'd0);
    idle_in();

    // Illegal request: both read and write.
    bus.mem_read  = 1'b1;
    bus.mem_write = 1'b1;
    bus.addr      = 32'h10;
    tick();
    idle_in();
    chk("err.err", 32'(bus.err), 32'd1);
    chk("err.busy", 32'(bus.busy), 32'd0);
    chk("err.rdy", 32'(bus.mem_ready), 32'd0);
    tick();
    chk("err.err2", 32'(bus.err), 32'd0);
    chk("err.busy2", 32'(bus.busy), 32'd0);
    chk("err.rdy2", 32'(bus.mem_ready), 32'd0);
    txn("err.rd20", 1'b1, 1'b0, 32'h20, 32'h0, 32'h22222222);

    // Address wrap modulo DEPTH and ignored byte offset.
    txn("wr400", 1'b0, 1'b1, 32'h400, 32'h12345678, 32'h22222222);
    txn("rd0", 1'b1, 1'b0, 32'h0, 32'h0, 32'h12345678);
    txn("rd3", 1'b1, 1'b0, 32'h3, 32'h0, 32'h12345678);
    txn("rd10b", 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);

    // Reset during WAIT aborts a write without committing it.
    txn("wr8", 1'b0, 1'b1, 32'h8, 32'h5555AAAA, 32'hDEADBEEF);
    bus.mem_write = 1'b1;
    bus.addr      = 32'h8;
    bus.data_in   = 32'hAAAA0000;
    tick();
    idle_in();
    chk("abort.busy1", 32'(bus.busy), 32'd1);
    tick();
    chk("abort.rdy2", 32'(bus.mem_ready), 32'd0);
    reset = 1'b1;
    tick();
    chk("abort.rdy", 32'(bus.mem_ready), 32'd0);
    chk("abort.busy", 32'(bus.busy), 32'd0);
    chk("abort.err", 32'(bus.err), 32'd0);
    chk("abort.dout", bus.data_out, 32'd0);
    reset = 1'b0;
    tick();
    chk("abort.rdy.post", 32'(bus.mem_ready), 32'd0);
    chk("abort.busy.post", 32'(bus.busy), 32'd0);
    txn("rd8", 1'b1, 1'b0, 32'h8, 32'h0, 32'h5555AAAA);

    // Reset asserted together with a request drops the request.
    bus.mem_read = 1'b1;
    bus.addr     = 32'h10;
    reset        = 1'b1;
    tick();
    reset = 1'b0;
    idle_in();
    chk("rstreq.busy", 32'(bus.busy), 32'd0);
    tick();
    chk("rstreq.busy2", 32'(bus.busy), 32'd0);
    tick();
    chk("rstreq.rdy", 32'(bus.mem_ready), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
